hs32_fetch: RTL and testbench
=============================

// Module: hs32_fetch
// PURPOSE
//  Instruction fetch stage; sits upstream of decode/exec. Issues sequential 32-bit
//  reads at PC through the memory arbiter port, buffers words in a small prefetch
//  queue, hands them to decode via valid/ready. Redirects on flush/newpc from exec.
// PARAMETERS
//  RESET_PC  32'h0  PC loaded on reset
//  QDEPTH    2      prefetch queue entries (power of two, >=2)
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, synchronous, active-high
//  newpc      in   32  branch target, sampled only when flush=1
//  flush      in   1   1-cycle redirect pulse from exec
//  addr       out  32  memory read address (== current fetch PC)
//  dtrm       in   32  memory read data, valid when reqm&&rdym
//  reqm       out  1   memory request; held until completion
//  rdym       in   1   memory ready; transfer completes on edge where reqm&&rdym
//  rw_mem     out  1   tied 0 (fetch only reads)
//  inst       out  32  instruction word to decode (queue head)
//  inst_pc    out  32  address of inst
//  inst_valid out  1   queue head valid
//  inst_ready in   1   decode accepts; pop on edge where inst_valid&&inst_ready
// BEHAVIOUR
//  Reset: pc=addr=RESET_PC, reqm=0, rw_mem=0, inst_valid=0, queue empty, state IDLE.
//   Reset mid-request drops reqm next edge; arbiter tolerates abandoned request.
//  States: IDLE (reqm=0), FETCH (reqm=1, result kept), DRAIN (reqm=1, result dropped).
//  IDLE -> FETCH when count+0 < QDEPTH and no flush; addr=pc already stable.
//  IDLE + flush: pc<=newpc, queue cleared, stay IDLE; request issued next cycle.
//  FETCH, reqm&&rdym, no flush: push {dtrm,pc}; pc<=pc+4 (mod 2^32, wraps silently);
//   -> FETCH if count after push/pop < QDEPTH, else IDLE.
//  FETCH, no rdym, flush: pc<=newpc, queue cleared -> DRAIN (request cannot abort).
//  FETCH, rdym and flush same edge: data discarded, pc<=newpc, queue cleared -> IDLE.
//  DRAIN, rdym: discard data -> IDLE (fetch at pc resumes next cycle). flush in DRAIN:
//   pc<=newpc again, stay DRAIN (or -> IDLE if rdym same edge).
//  addr only changes when reqm=0 or on completion edge; never while request pending.
//  Queue: push on completion, pop on inst_valid&&inst_ready; simultaneous push+pop
//   allowed at any count incl. full. Requests never issued when count==QDEPTH, so
//   overflow impossible; push into full queue is an assertion failure.
//  Flush overrides pop: queue cleared, inst_valid=0 next cycle regardless of inst_ready.
//  Latency: completion at edge N -> inst_valid=1 after edge N (combinational head).
//   flush at edge N (no pending req) -> reqm=1, addr=newpc after edge N+1.
//  Throughput: back-to-back completions supported with rdym held 1 (1 word/cycle
//   after first), reqm stays 1 between words when queue has room.
//  inst/inst_pc are don't-care when inst_valid=0; stable while valid&&!ready.
// STRUCTURE
//  Shared header (hs32_xuconst-style): fetch state encodings FS_IDLE/FS_FETCH/FS_DRAIN.
//  Sub-module hs32_fetch_q: sync FIFO, width 64 ({pc,inst}), depth QDEPTH, ports
//   push/pop/clear/full/empty/count; clear has priority over push and pop.
//  Top: FSM, pc register, memory handshake, glue.
// TESTING
//  Reset, rdym=1 always, inst_ready=1 -> addr 0,4,8,...; inst_pc 0,4,8 in order, no gaps.
//  inst_ready=0, rdym=1 -> exactly 2 reads (addr 0,4), reqm=0 after, inst_pc=0 held.
//  rdym delayed 3 cycles, flush newpc=0x100 while pending -> DRAIN, old word dropped,
//   next reqm with addr=0x100, first inst_pc=0x100.
//  flush on same edge as completion and pop -> queue empty, inst_valid=0, next addr=newpc.
//  pc=0xFFFFFFFC fetch -> next addr=0x00000000.
//  reset asserted in FETCH -> reqm=0, addr=RESET_PC, inst_valid=0 after edge.

Source files
------------

// File: rtl/hs32_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and the prefetch queue entry layout.
// Pure types and constants; no latency or backpressure of its own.
package hs32_fetch_pkg;

    localparam int          XLEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } qent_t;

endpackage

// File: rtl/hs32_fetch_if.sv
// Fetch-stage bundle: exec redirect, memory arbiter read port and decode hand-off.
// Master is the fetch stage; slave is the surrounding pipeline and arbiter.
interface hs32_fetch_if;
    import hs32_fetch_pkg::*;

    logic [XLEN-1:0] newpc;
    logic            flush;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] dtrm;
    logic            reqm;
    logic            rdym;
    logic            rw_mem;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;

    modport master (
        input  newpc, flush, dtrm, rdym, inst_ready,
        output addr, reqm, rw_mem, inst, inst_pc, inst_valid
    );

    modport slave (
        output newpc, flush, dtrm, rdym, inst_ready,
        input  addr, reqm, rw_mem, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/hs32_fetch_q.sv
// Synchronous prefetch FIFO with combinational head; push+pop allowed when full.
// clear wins over push and pop; producer must never push into a full queue without a pop.
module hs32_fetch_q #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           wdat_i,
    output logic [WIDTH-1:0]           rdat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdat_i;
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear_i) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("hs32_fetch_q: push into full queue");
        end
    end

    assign rdat_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/hs32_fetch.sv
// Instruction fetch: sequential reads at PC into a prefetch queue, redirect on flush.
// Word visible to decode the cycle after completion; requests stop while the queue is full.
module hs32_fetch
    import hs32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          QDEPTH   = 2
) (
    input logic           clk,
    input logic           reset,
    hs32_fetch_if.master  bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic            q_push, q_pop, q_clear;
    logic            q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   cnt_after;
    qent_t           q_wdat, q_rdat;

    assign q_pop     = !q_empty && bus.inst_ready;
    assign cnt_after = q_count + CW'(1) - CW'(q_pop);
    assign q_wdat    = '{pc: pc_q, inst: bus.dtrm};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        q_push  = 1'b0;
        q_clear = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (bus.flush) begin
                    pc_d    = bus.newpc;
                    q_clear = 1'b1;
                end else if (!q_full) begin
                    state_d = FS_FETCH;
                end
            end
            FS_FETCH: begin
                if (bus.rdym) begin
                    if (bus.flush) begin
                        pc_d    = bus.newpc;
                        q_clear = 1'b1;
                        state_d = FS_IDLE;
                    end else begin
                        q_push  = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = (cnt_after < CW'(QDEPTH)) ? FS_FETCH : FS_IDLE;
                    end
                end else if (bus.flush) begin
                    // The arbiter cannot abort; wait out the stale word in DRAIN.
                    pc_d    = bus.newpc;
                    q_clear = 1'b1;
                    state_d = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                if (bus.flush) begin
                    pc_d    = bus.newpc;
                    q_clear = 1'b1;
                end
                if (bus.rdym) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // The request address may only move when no request is outstanding.
    assign addr_d = (!bus.reqm || bus.rdym) ? pc_d : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    hs32_fetch_q #(
        .WIDTH ($bits(qent_t)),
        .DEPTH (QDEPTH)
    ) u_q (
        .clk     (clk),
        .reset   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .wdat_i  (q_wdat),
        .rdat_o  (q_rdat),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign bus.addr       = addr_q;
    assign bus.reqm       = (state_q != FS_IDLE);
    assign bus.rw_mem     = 1'b0;
    assign bus.inst       = q_rdat.inst;
    assign bus.inst_pc    = q_rdat.pc;
    assign bus.inst_valid = !q_empty;
endmodule

// File: tb/tb_hs32_fetch.sv
// Bench for hs32_fetch: directed scenarios plus randomized traffic against a
// transaction-level model (expected-word queue, next fetch address, pending-drop flag).
module tb_hs32_fetch;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hs32_fetch_if bus();

    hs32_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Arbiter data bus: fresh random word every cycle, model captures it at completion.
    initial begin
        bus.dtrm = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.dtrm = $urandom;
        end
    end

    logic [63:0] mq[$];
    logic [31:0] mpc = RESET_PC;
    bit          drain = 1'b0;
    bit          live = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (live) begin
            total++;
            if (bus.inst_valid !== (mq.size() != 0)) begin
                bad++;
                $display("FAIL sb_valid: got %b want %b at %0t", bus.inst_valid, (mq.size() != 0), $time);
            end
            if (mq.size() != 0 && bus.inst_valid === 1'b1) begin
                total++;
                if ({bus.inst_pc, bus.inst} !== mq[0]) begin
                    bad++;
                    $display("FAIL sb_head: got pc=%h inst=%h want pc=%h inst=%h at %0t",
                             bus.inst_pc, bus.inst, mq[0][63:32], mq[0][31:0], $time);
                end
            end
            if (bus.reqm === 1'b1 && !drain) begin
                total++;
                if (bus.addr !== mpc) begin
                    bad++;
                    $display("FAIL sb_addr: got %h want %h at %0t", bus.addr, mpc, $time);
                end
            end
            if (mq.size() >= QDEPTH) begin
                total++;
                if (bus.reqm !== 1'b0) begin
                    bad++;
                    $display("FAIL sb_full_req: got reqm=%b want 0 at %0t", bus.reqm, $time);
                end
            end
            total++;
            if (bus.rw_mem !== 1'b0) begin
                bad++;
                $display("FAIL sb_rw_mem: got %b want 0 at %0t", bus.rw_mem, $time);
            end
            if (prev_pend) begin
                total++;
                if (bus.addr !== prev_addr) begin
                    bad++;
                    $display("FAIL sb_addr_hold: got %h want %h at %0t", bus.addr, prev_addr, $time);
                end
            end
        end

        prev_pend = live && !reset && bus.reqm === 1'b1 && bus.rdym !== 1'b1;
        prev_addr = bus.addr;

        if (reset) begin
            mq.delete();
            mpc   = RESET_PC;
            drain = 1'b0;
            live  = 1'b1;
        end else if (live) begin
            if (bus.flush) begin
                mq.delete();
                mpc   = bus.newpc;
                drain = (bus.reqm === 1'b1) && !bus.rdym;
            end else begin
                if (mq.size() != 0 && bus.inst_ready) void'(mq.pop_front());
                if (bus.reqm === 1'b1 && bus.rdym) begin
                    if (drain) drain = 1'b0;
                    else begin
                        mq.push_back({mpc, bus.dtrm});
                        mpc = mpc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.newpc      = 32'h0;
        bus.rdym       = 1'b0;
        bus.inst_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.reqm !== 1'b0) begin bad++; $display("FAIL reset_reqm: got %b want 0", bus.reqm); end
        total++; if (bus.addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", bus.addr, RESET_PC); end
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
        step();
        total++; if (bus.reqm !== 1'b1) begin bad++; $display("FAIL reset_first_req: got %b want 1", bus.reqm); end
        total++; if (bus.addr !== RESET_PC) begin bad++; $display("FAIL reset_first_addr: got %h want %h", bus.addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = RESET_PC;
        int n = 0;
        do_reset();
        bus.rdym = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (24) begin
            if (bus.inst_valid === 1'b1) begin
                total++;
                if (bus.inst_pc !== exp_pc) begin
                    bad++;
                    $display("FAIL stream_pc: got %h want %h", bus.inst_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            step();
        end
        total++;
        if (n != 22) begin bad++; $display("FAIL stream_count: got %0d want 22", n); end
    endtask

    task automatic test_backpressure();
        int reads = 0;
        do_reset();
        bus.rdym = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (8) begin
            if (bus.reqm === 1'b1 && bus.rdym) reads++;
            step();
        end
        total++; if (reads != 2) begin bad++; $display("FAIL bp_reads: got %0d want 2", reads); end
        total++; if (bus.reqm !== 1'b0) begin bad++; $display("FAIL bp_reqm: got %b want 0", bus.reqm); end
        total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got %h want 0", bus.inst_pc); end
        bus.inst_ready = 1'b1;
        step();
        total++; if (bus.inst_pc !== 32'h4) begin bad++; $display("FAIL bp_second: got %h want 4", bus.inst_pc); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        total++; if (bus.reqm !== 1'b1) begin bad++; $display("FAIL drain_req: got %b want 1", bus.reqm); end
        step();
        bus.flush = 1'b1;
        bus.newpc = 32'h100;
        step();
        bus.flush = 1'b0;
        total++; if (bus.reqm !== 1'b1) begin bad++; $display("FAIL drain_hold_req: got %b want 1", bus.reqm); end
        total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL drain_hold_addr: got %h want 0", bus.addr); end
        step();
        bus.rdym = 1'b1;
        step();
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL drain_dropped: got %b want 0", bus.inst_valid); end
        step();
        total++; if (bus.reqm !== 1'b1) begin bad++; $display("FAIL drain_newreq: got %b want 1", bus.reqm); end
        total++; if (bus.addr !== 32'h100) begin bad++; $display("FAIL drain_newaddr: got %h want 100", bus.addr); end
        step();
        total++; if (bus.inst_pc !== 32'h100 || bus.inst_valid !== 1'b1) begin
            bad++; $display("FAIL drain_first_pc: got %h/%b want 100/1", bus.inst_pc, bus.inst_valid);
        end
    endtask

    task automatic test_flush_complete();
        do_reset();
        bus.rdym = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (4) step();
        total++; if (bus.reqm !== 1'b1 || bus.inst_valid !== 1'b1) begin
            bad++; $display("FAIL fc_busy: got reqm=%b valid=%b want 1/1", bus.reqm, bus.inst_valid);
        end
        bus.flush = 1'b1;
        bus.newpc = 32'h2000;
        step();
        bus.flush = 1'b0;
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL fc_valid: got %b want 0", bus.inst_valid); end
        total++; if (bus.reqm !== 1'b0) begin bad++; $display("FAIL fc_idle: got %b want 0", bus.reqm); end
        step();
        total++; if (bus.reqm !== 1'b1 || bus.addr !== 32'h2000) begin
            bad++; $display("FAIL fc_newreq: got %b/%h want 1/2000", bus.reqm, bus.addr);
        end
        step();
        total++; if (bus.inst_pc !== 32'h2000) begin bad++; $display("FAIL fc_first_pc: got %h want 2000", bus.inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.flush = 1'b1;
        bus.newpc = 32'hFFFF_FFFC;
        step();
        bus.flush = 1'b0;
        bus.rdym = 1'b1;
        bus.inst_ready = 1'b1;
        step();
        total++; if (bus.reqm !== 1'b1 || bus.addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", bus.reqm, bus.addr);
        end
        step();
        total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 0", bus.addr); end
        total++; if (bus.inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %h want fffffffc", bus.inst_pc); end
        step();
        total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL wrap_next_pc: got %h want 0", bus.inst_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rdym = 1'b1;
        step();
        step();
        bus.rdym = 1'b0;
        step();
        total++; if (bus.reqm !== 1'b1 || bus.inst_valid !== 1'b1) begin
            bad++; $display("FAIL rm_busy: got reqm=%b valid=%b want 1/1", bus.reqm, bus.inst_valid);
        end
        reset = 1'b1;
        step();
        total++; if (bus.reqm !== 1'b0) begin bad++; $display("FAIL rm_reqm: got %b want 0", bus.reqm); end
        total++; if (bus.addr !== RESET_PC) begin bad++; $display("FAIL rm_addr: got %h want %h", bus.addr, RESET_PC); end
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", bus.inst_valid); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int pops = 0;
        do_reset();
        repeat (3000) begin
            bus.rdym       = $urandom_range(0, 1) == 1;
            bus.inst_ready = $urandom_range(0, 9) < 6;
            bus.flush      = $urandom_range(0, 19) == 0;
            bus.newpc      = $urandom & 32'hFFFF_FFFC;
            if (bus.inst_valid === 1'b1 && bus.inst_ready) pops++;
            step();
        end
        bus.flush = 1'b0;
        total++;
        if (pops < 200) begin bad++; $display("FAIL rand_progress: got %0d pops want >=200", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_flush_complete();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
